bsg_fsb_murn_node_buffer: RTL and testbench

Elastic receive buffer between the FSB murn gateway and its attached node. It accepts packets the gateway has already addressed to this node, stores up to `els_p` of them, and presents them to the node with a valid/yumi handshake. It tracks the gateway's node-enable and node-reset controls, flushing and discarding traffic while the node is held in reset. A saturating counter records every discarded packet for debug.

---
 rtl/bsg_fsb_murn_pkg.sv | 5 +
 rtl/bsg_fsb_murn_node_buffer_if.sv | 29 ++
 rtl/bsg_fsb_murn_node_buffer_mem.sv | 21 ++
 rtl/bsg_fsb_murn_node_buffer.sv | 76 +++++++
 tb/tb_bsg_fsb_murn_node_buffer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/bsg_fsb_murn_pkg.sv
// Shared FSB murn constants used by the node-side receive path.
package bsg_fsb_murn_pkg;
   localparam int fsb_width_gp     = 128;
   localparam int drop_cnt_width_gp = 16;
endpackage

// File: rtl/bsg_fsb_murn_node_buffer_if.sv
// Gateway-side and node-side signals of the murn node buffer.
interface bsg_fsb_murn_node_buffer_if
   import bsg_fsb_murn_pkg::*;
#(
   parameter int width_p          = fsb_width_gp,
   parameter int els_p            = 4,
   parameter int drop_cnt_width_p = drop_cnt_width_gp
);
   logic                        v_i;
   logic [width_p-1:0]          data_i;
   logic                        ready_o;
   logic                        node_en_i;
   logic                        node_reset_i;
   logic                        v_o;
   logic [width_p-1:0]          data_o;
   logic                        yumi_i;
   logic [$clog2(els_p+1)-1:0]  count_o;
   logic [drop_cnt_width_p-1:0] drop_cnt_o;

   modport slave (
      input  v_i, data_i, node_en_i, node_reset_i, yumi_i,
      output ready_o, v_o, data_o, count_o, drop_cnt_o
   );

   modport master (
      output v_i, data_i, node_en_i, node_reset_i, yumi_i,
      input  ready_o, v_o, data_o, count_o, drop_cnt_o
   );
endinterface

// File: rtl/bsg_fsb_murn_node_buffer_mem.sv
// Packet storage: one write port, one asynchronous read port, no data reset.
module bsg_fsb_murn_node_buffer_mem #(
   parameter int width_p = 128,
   parameter int els_p   = 4,
   localparam int ptr_w  = $clog2(els_p)
) (
   input  logic               clk_i,
   input  logic               w_v_i,
   input  logic [ptr_w-1:0]   w_addr_i,
   input  logic [width_p-1:0] w_data_i,
   input  logic [ptr_w-1:0]   r_addr_i,
   output logic [width_p-1:0] r_data_o
);
   logic [width_p-1:0] mem_q [els_p];

   always_ff @(posedge clk_i) begin
      if (w_v_i) mem_q[w_addr_i] <= w_data_i;
   end

   assign r_data_o = mem_q[r_addr_i];
endmodule

// File: rtl/bsg_fsb_murn_node_buffer.sv
// Elastic receive buffer between the murn gateway and its node; flushes and
// counts discarded packets while the node is held in reset.
module bsg_fsb_murn_node_buffer
   import bsg_fsb_murn_pkg::*;
#(
   parameter int width_p          = fsb_width_gp,
   parameter int els_p            = 4,
   parameter int drop_cnt_width_p = drop_cnt_width_gp
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   bsg_fsb_murn_node_buffer_if.slave    bus
);
   localparam int ptr_w = $clog2(els_p);
   localparam int cnt_w = $clog2(els_p+1);

   logic [ptr_w-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [cnt_w-1:0]            count_q, count_d;
   logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;
   logic                        ready, v_out, wr_en, deq;

   // Held node always accepts so the ring never backs up behind it.
   assign ready = (count_q != cnt_w'(els_p)) | bus.node_reset_i;
   assign v_out = (count_q != '0) & bus.node_en_i & ~bus.node_reset_i;
   assign wr_en = bus.v_i & ready & ~bus.node_reset_i;
   assign deq   = bus.yumi_i & v_out;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      if (bus.node_reset_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (bus.v_i && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + drop_cnt_width_p'(1);
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + ptr_w'(1);
         if (deq)   rd_ptr_d = rd_ptr_q + ptr_w'(1);
         count_d = count_q + cnt_w'(wr_en) - cnt_w'(deq);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   bsg_fsb_murn_node_buffer_mem #(.width_p(width_p), .els_p(els_p)) mem (
      .clk_i    (clk_i),
      .w_v_i    (wr_en),
      .w_addr_i (wr_ptr_q),
      .w_data_i (bus.data_i),
      .r_addr_i (rd_ptr_q),
      .r_data_o (bus.data_o)
   );

   assign bus.ready_o    = ready;
   assign bus.v_o        = v_out;
   assign bus.count_o    = count_q;
   assign bus.drop_cnt_o = drop_cnt_q;

   a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
      bus.yumi_i |-> v_out);
endmodule

// File: tb/tb_bsg_fsb_murn_node_buffer.sv
// Directed bench for the murn node buffer: vector table plus corner sequences.
module tb_bsg_fsb_murn_node_buffer;
   localparam int W = 128;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bsg_fsb_murn_node_buffer_if #(.width_p(W), .els_p(4), .drop_cnt_width_p(4)) bus ();

   bsg_fsb_murn_node_buffer #(.width_p(W), .els_p(4), .drop_cnt_width_p(4)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   typedef struct {
      logic       v, en, nr, y;
      logic [7:0] d;
      logic       r_e, v_e;
      int         c_e;
      logic [7:0] d_e;
      bit         dchk;
      int         drop_e;
   } vec_t;

   int tests = 0;
   int fails = 0;
   vec_t tbl [30];

   function automatic vec_t mk(logic v, logic [7:0] d, logic en, logic nr, logic y,
                               logic r_e, logic v_e, int c_e, bit dchk,
                               logic [7:0] d_e, int drop_e);
      vec_t t;
      t.v = v; t.d = d; t.en = en; t.nr = nr; t.y = y;
      t.r_e = r_e; t.v_e = v_e; t.c_e = c_e; t.dchk = dchk; t.d_e = d_e;
      t.drop_e = drop_e;
      return t;
   endfunction

   function automatic logic [W-1:0] pat(logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic v, logic [7:0] d, logic en, logic nr, logic y);
      @(negedge clk);
      bus.v_i = v; bus.data_i = pat(d); bus.node_en_i = en;
      bus.node_reset_i = nr; bus.yumi_i = y;
      #1;
   endtask

   initial begin
      // fill / drain; full buffer refuses 0xEE even while the node yumis
      tbl[0]  = mk(1,8'hA0,1,0,0, 1,0,0, 0,8'h00, 0);
      tbl[1]  = mk(1,8'hA1,1,0,0, 1,1,1, 1,8'hA0, 0);
      tbl[2]  = mk(1,8'hA2,1,0,0, 1,1,2, 1,8'hA0, 0);
      tbl[3]  = mk(1,8'hA3,1,0,0, 1,1,3, 1,8'hA0, 0);
      tbl[4]  = mk(1,8'hEE,1,0,1, 0,1,4, 1,8'hA0, 0);
      tbl[5]  = mk(0,8'h00,1,0,1, 1,1,3, 1,8'hA1, 0);
      tbl[6]  = mk(0,8'h00,1,0,1, 1,1,2, 1,8'hA2, 0);
      tbl[7]  = mk(0,8'h00,1,0,1, 1,1,1, 1,8'hA3, 0);
      tbl[8]  = mk(0,8'h00,1,0,0, 1,0,0, 0,8'h00, 0);
      // disable hold
      tbl[9]  = mk(1,8'hB0,1,0,0, 1,0,0, 0,8'h00, 0);
      tbl[10] = mk(1,8'hB1,1,0,0, 1,1,1, 1,8'hB0, 0);
      tbl[11] = mk(0,8'h00,0,0,0, 1,0,2, 0,8'h00, 0);
      tbl[12] = mk(0,8'h00,0,0,0, 1,0,2, 0,8'h00, 0);
      tbl[13] = mk(0,8'h00,0,0,0, 1,0,2, 0,8'h00, 0);
      tbl[14] = mk(0,8'h00,0,0,0, 1,0,2, 0,8'h00, 0);
      tbl[15] = mk(0,8'h00,0,0,0, 1,0,2, 0,8'h00, 0);
      tbl[16] = mk(0,8'h00,1,0,1, 1,1,2, 1,8'hB0, 0);
      tbl[17] = mk(0,8'h00,1,0,1, 1,1,1, 1,8'hB1, 0);
      tbl[18] = mk(0,8'h00,1,0,0, 1,0,0, 0,8'h00, 0);
      // reset flush with traffic every cycle
      tbl[19] = mk(1,8'hC0,1,0,0, 1,0,0, 0,8'h00, 0);
      tbl[20] = mk(1,8'hC1,1,0,0, 1,1,1, 1,8'hC0, 0);
      tbl[21] = mk(1,8'hC2,1,0,0, 1,1,2, 1,8'hC0, 0);
      tbl[22] = mk(1,8'hD0,1,1,0, 1,0,3, 0,8'h00, 0);
      tbl[23] = mk(1,8'hD1,1,1,0, 1,0,0, 0,8'h00, 1);
      tbl[24] = mk(1,8'hD2,1,1,0, 1,0,0, 0,8'h00, 2);
      tbl[25] = mk(1,8'hD3,1,1,0, 1,0,0, 0,8'h00, 3);
      tbl[26] = mk(1,8'hC3,1,0,0, 1,0,0, 0,8'h00, 4);
      tbl[27] = mk(0,8'h00,1,0,0, 1,1,1, 1,8'hC3, 4);
      tbl[28] = mk(0,8'h00,1,0,1, 1,1,1, 1,8'hC3, 4);
      tbl[29] = mk(0,8'h00,1,0,0, 1,0,0, 0,8'h00, 4);

      rst = 1'b1;
      bus.v_i = 0; bus.data_i = '0; bus.node_en_i = 1;
      bus.node_reset_i = 0; bus.yumi_i = 0;
      #12;
      chk("rst_ready", W'(bus.ready_o), W'(1));
      chk("rst_v", W'(bus.v_o), W'(0));
      chk("rst_count", W'(bus.count_o), W'(0));
      chk("rst_drop", W'(bus.drop_cnt_o), W'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].nr, tbl[i].y);
         chk($sformatf("vec%0d_ready", i), W'(bus.ready_o), W'(tbl[i].r_e));
         chk($sformatf("vec%0d_v", i), W'(bus.v_o), W'(tbl[i].v_e));
         chk($sformatf("vec%0d_count", i), W'(bus.count_o), W'(tbl[i].c_e));
         chk($sformatf("vec%0d_drop", i), W'(bus.drop_cnt_o), W'(tbl[i].drop_e));
         if (tbl[i].dchk)
            chk($sformatf("vec%0d_data", i), bus.data_o, pat(tbl[i].d_e));
      end

      // streaming: 20 packets, push and yumi together, across pointer wrap
      for (int i = 0; i < 20; i++) begin
         drive(1, 8'(8'h50 + i), 1, 0, i > 0);
         if (i > 0) begin
            chk($sformatf("strm%0d_count", i), W'(bus.count_o), W'(1));
            chk($sformatf("strm%0d_data", i), bus.data_o, pat(8'(8'h50 + i - 1)));
         end
      end
      drive(0, 8'h00, 1, 0, 1);
      chk("strm_last_data", bus.data_o, pat(8'h63));
      drive(0, 8'h00, 1, 0, 0);
      chk("strm_end_count", W'(bus.count_o), W'(0));
      chk("strm_end_v", W'(bus.v_o), W'(0));

      // saturation: 4 drops already, 20 more on a 4-bit counter
      for (int i = 0; i < 20; i++) begin
         drive(1, 8'hF0, 1, 1, 0);
         if (i == 10) chk("sat_mid_drop", W'(bus.drop_cnt_o), W'(14));
      end
      drive(0, 8'h00, 1, 0, 0);
      chk("sat_drop", W'(bus.drop_cnt_o), W'(15));

      // async reset at occupancy 3, between edges
      drive(1, 8'h11, 1, 0, 0);
      drive(1, 8'h12, 1, 0, 0);
      drive(1, 8'h13, 1, 0, 0);
      drive(0, 8'h00, 1, 0, 0);
      chk("ar_pre_count", W'(bus.count_o), W'(3));
      rst = 1'b1;
      #1;
      chk("ar_count", W'(bus.count_o), W'(0));
      chk("ar_v", W'(bus.v_o), W'(0));
      chk("ar_drop", W'(bus.drop_cnt_o), W'(0));
      chk("ar_ready", W'(bus.ready_o), W'(1));
      @(negedge clk);
      rst = 1'b0;
      drive(1, 8'h77, 1, 0, 0);
      drive(0, 8'h00, 1, 0, 0);
      chk("post_ar_data", bus.data_o, pat(8'h77));
      chk("post_ar_count", W'(bus.count_o), W'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
